pc_seq: RTL and testbench
=========================

// Module: pc_seq
// PURPOSE
//  Parametrised program-counter sequencer: next-generation PC for the single-cycle MIPS core.
//  Generates the fetch address each cycle from PC+4, BEQ/BNE, J/JAL, JR and return targets.
//  Adds stall/halt control, a boot state, misaligned-target trap and an optional return-address stack.
//  Sits between the control unit/ALU zero flag and the instruction memory address port.
// PARAMETERS
//  ADDR_W     32            PC/address width (>=28)
//  RESET_VEC  32'h0000_0000 addr value while reset and at boot
//  TRAP_VEC   32'h0000_0080 target on misaligned JR or RAS underflow
//  RAS_DEPTH  4             return-stack entries (power of 2; used only with PC_RAS_EN)
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-high
//  instruction  in   32      current instr; imm16=[15:0], target26=[25:0]
//  branch       in   1       BEQ: take if zero=1
//  branch_ne    in   1       BNE: take if zero=0
//  zero         in   1       ALU zero flag
//  jump         in   1       J-type jump
//  jal          in   1       J-type jump and link (push PC+4)
//  jr           in   1       jump to jr_addr
//  ret          in   1       return (pop RAS; without PC_RAS_EN acts as jr)
//  jr_addr      in   ADDR_W  register target for jr/ret
//  stall        in   1       hold PC this cycle
//  halt         in   1       enter HALT
//  resume       in   1       leave HALT
//  addr         out  ADDR_W  current fetch address (registered)
//  pc_plus4     out  ADDR_W  addr+4 (combinational, link value)
//  fetch_valid  out  1       addr is a live fetch
//  trap         out  1       one-cycle pulse: trap target loaded
//  ras_full     out  1       RAS full (0 without PC_RAS_EN)
//  ras_empty    out  1       RAS empty (1 without PC_RAS_EN)
// BEHAVIOUR
//  Reset (sync, high): state=BOOT, addr=RESET_VEC, fetch_valid=0, trap=0, RAS emptied; overrides all.
//  FSM BOOT->RUN on first clock with reset=0 (addr held); RUN->HALT on halt; HALT->RUN on resume.
//  fetch_valid=1 only in RUN. HALT: addr frozen, control inputs discarded; halt+resume same cycle: halt wins.
//  RUN next-addr priority: halt > stall(hold) > ret > jr > jal/jump > taken branch > pc_plus4.
//  Branch target = pc_plus4 + (sext(imm16) << 2); jump target = {pc_plus4[ADDR_W-1:28], target26, 2'b00}.
//  jr/ret target = jr_addr (or popped RAS); if target[1:0]!=0 -> addr=TRAP_VEC, trap=1 for 1 cycle.
//  All arithmetic modulo 2^ADDR_W; wrap from all-ones-minus-3 to 0 is silent.
//  branch and branch_ne both high: taken if either condition true. Latency: target visible 1 cycle after edge.
//  Stall: addr held, fetch_valid stays 1, no RAS push/pop, trap not raised.
// CONFIGURATION
//  PC_RAS_EN defined: RAS_DEPTH-entry circular stack; jal pushes pc_plus4; ret pops into addr.
//   Push when full overwrites oldest (ras_full stays 1); pop when empty -> TRAP_VEC, trap=1.
//   ret and jal same cycle: ret wins, no push.
//  PC_RAS_EN undefined: no stack; ret behaves exactly as jr; jal behaves as jump; ras_full=0, ras_empty=1.
// STRUCTURE
//  Shared header pc_defs.vh: FSM state codes (BOOT/RUN/HALT), imm16/target26 field positions, default vectors.
//  Sub-module pc_ras (push/pop/full/empty, depth param), instantiated only under PC_RAS_EN.
//  Top holds FSM, target mux, trap logic.
// TESTING
//  Reset 2 cycles, release, 3 clocks -> addr 0,0(BOOT),4,8; fetch_valid 0 then 1 from RUN.
//  At addr=8, branch=1 zero=1 instr=0x0000_1000 -> addr=0x0000_400C; then imm16=0xFF98 -> 0x0000_3E70.
//  branch_ne=1 zero=1 -> not taken, addr+4; jump target26=0x0080000 at 0x3E70 -> addr=0x0020_0000.
//  jr jr_addr=0x0000_1002 -> addr=0x80, trap=1 exactly one cycle; jr 0x1000 -> 0x1000, trap=0.
//  stall 3 cycles then halt 2 cycles then resume -> addr constant throughout, fetch_valid 1,1,1,0,0,1.
//  PC_RAS_EN: jal at 0x100 -> push 0x104; ret -> addr=0x104; ret on empty -> 0x80, trap=1; 5 pushes depth 4 -> ras_full=1.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: FSM state codes, instruction field widths, default vectors and branch decision shared by pc_seq
package pc_seq_pkg;
  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;
  localparam int IMM_W = 16;
  localparam int TGT_W = 26;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0080;
  function automatic logic branch_taken(input logic beq, input logic bne, input logic zero);
    return (beq & zero) | (bne & ~zero);
  endfunction
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry
module pc_ras #(
  parameter int W = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW:0] cnt;
  assign top = mem[ptr - 1'b1];
  assign full = cnt == (PW+1)'(DEPTH);
  assign empty = cnt == '0;
  always_ff @(posedge clk)
    if (push) mem[ptr] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push) begin
      ptr <= ptr + 1'b1;
      cnt <= full ? cnt : cnt + 1'b1;
    end else if (pop && !empty) begin
      ptr <= ptr - 1'b1;
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer with BOOT/RUN/HALT FSM, branch/jump/jr targets and misaligned trap.
// Define PC_RAS_EN to add the pc_ras return-address stack (jal pushes, ret pops).
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
  parameter logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'(DEF_TRAP_VEC),
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic              branch,
  input  logic              branch_ne,
  input  logic              zero,
  input  logic              jump,
  input  logic              jal,
  input  logic              jr,
  input  logic              ret,
  input  logic [ADDR_W-1:0] jr_addr,
  input  logic              stall,
  input  logic              halt,
  input  logic              resume,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              fetch_valid,
  output logic              trap,
  output logic              ras_full,
  output logic              ras_empty
);
  state_t state, state_n;
  logic [ADDR_W-1:0] br_tgt, jmp_tgt, ind_tgt, ret_src, addr_n;
  logic live, indirect, ret_under, bad, trap_n, unused;
  assign pc_plus4 = addr + ADDR_W'(4);
`ifdef PC_RAS_EN
  logic push, pop;
  assign push = live & jal & ~ret & ~jr;
  assign pop = live & ret & ~ras_empty;
  assign ret_under = ras_empty;
  assign unused = ^instruction[31:TGT_W];
  pc_ras #(.W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(pc_plus4),
    .top(ret_src), .full(ras_full), .empty(ras_empty)
  );
`else
  assign ret_src = jr_addr;
  assign ret_under = 1'b0;
  assign ras_full = 1'b0;
  assign ras_empty = 1'b1;
  assign unused = ^{instruction[31:TGT_W], RAS_DEPTH == 0};
`endif
  always_ff @(posedge clk)
    state <= reset ? ST_BOOT : state_n;
  always_comb
    state_n = state == ST_BOOT ? ST_RUN :
              state == ST_RUN ? (halt ? ST_HALT : ST_RUN) :
              (resume && !halt) ? ST_RUN : ST_HALT;
  always_comb
    fetch_valid = state == ST_RUN;
  // Jump keeps the top bits above the 28-bit word-addressed target field.
  always_comb begin
    br_tgt = pc_plus4 + {{(ADDR_W-IMM_W-2){instruction[IMM_W-1]}}, instruction[IMM_W-1:0], 2'b00};
    jmp_tgt = (pc_plus4 & ~ADDR_W'(28'hFFF_FFFF)) | ADDR_W'({instruction[TGT_W-1:0], 2'b00});
    live = (state == ST_RUN) & ~halt & ~stall;
    indirect = ret | jr;
    ind_tgt = ret ? ret_src : jr_addr;
    bad = indirect & ((ret & ret_under) | (ind_tgt[1:0] != 2'b00));
    trap_n = live & bad;
    addr_n = !live ? addr :
             bad ? TRAP_VEC :
             indirect ? ind_tgt :
             (jal | jump) ? jmp_tgt :
             branch_taken(branch, branch_ne, zero) ? br_tgt : pc_plus4;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= RESET_VEC;
      trap <= 1'b0;
    end else begin
      addr <= addr_n;
      trap <= trap_n;
    end
  end
endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed plus random stimulus, expectations queued by a behavioural model and checked by a monitor
module tb_pc_seq;
  logic clk = 0, reset = 1;
  logic [31:0] instruction = 0, jr_addr = 0;
  logic branch = 0, branch_ne = 0, zero = 0, jump = 0, jal = 0, jr = 0, ret = 0;
  logic stall = 0, halt = 0, resume = 0;
  logic [31:0] addr, pc_plus4;
  logic fetch_valid, trap, ras_full, ras_empty;
  always #5 clk = ~clk;
  pc_seq dut (
    .clk(clk), .reset(reset), .instruction(instruction), .branch(branch), .branch_ne(branch_ne),
    .zero(zero), .jump(jump), .jal(jal), .jr(jr), .ret(ret), .jr_addr(jr_addr), .stall(stall),
    .halt(halt), .resume(resume), .addr(addr), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
    .trap(trap), .ras_full(ras_full), .ras_empty(ras_empty)
  );
  typedef struct {logic [31:0] addr; logic fv, trap, full, empty;} exp_t;
  exp_t exp_q[$];
  int vectors = 0, miscompares = 0;
  logic [31:0] m_addr = 0;
  int m_mode = 0;
  logic [31:0] ras[$];

  task automatic clr();
    {branch, branch_ne, zero, jump, jal, jr, ret, stall, halt, resume} = '0;
    instruction = 0;
    jr_addr = 0;
  endtask

  // Model: mode 0=boot 1=run 2=halt; computes the state visible after the coming edge.
  task automatic tick();
    logic [31:0] p4, tgt;
    logic tr;
    exp_t e;
    tr = 0;
    p4 = m_addr + 4;
    if (reset) begin
      m_addr = 32'h0; m_mode = 0; ras.delete();
    end else if (m_mode == 0) m_mode = 1;
    else if (m_mode == 2) begin
      if (resume && !halt) m_mode = 1;
    end else if (halt) m_mode = 2;
    else if (!stall) begin
      if (ret || jr) begin
        tgt = jr_addr;
`ifdef PC_RAS_EN
        if (ret) begin
          if (ras.size() == 0) tr = 1;
          else tgt = ras.pop_back();
        end
`endif
        if (tgt[1:0] != 0) tr = 1;
        m_addr = tr ? 32'h80 : tgt;
      end else if (jal || jump) begin
`ifdef PC_RAS_EN
        if (jal) begin
          ras.push_back(p4);
          if (ras.size() > 4) void'(ras.pop_front());
        end
`endif
        m_addr = {p4[31:28], instruction[25:0], 2'b00};
      end else if ((branch && zero) || (branch_ne && !zero))
        m_addr = p4 + 32'(4 * int'($signed(instruction[15:0])));
      else m_addr = p4;
    end
    e.addr = m_addr;
    e.fv = m_mode == 1;
    e.trap = tr;
`ifdef PC_RAS_EN
    e.full = ras.size() == 4;
    e.empty = ras.size() == 0;
`else
    e.full = 0;
    e.empty = 1;
`endif
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, expv, $time);
    end
  endtask

  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("addr", addr, e.addr);
      chk("pc_plus4", pc_plus4, e.addr + 32'd4);
      chk("fetch_valid", 32'(fetch_valid), 32'(e.fv));
      chk("trap", 32'(trap), 32'(e.trap));
      chk("ras_full", 32'(ras_full), 32'(e.full));
      chk("ras_empty", 32'(ras_empty), 32'(e.empty));
    end
  end

  initial begin
    @(negedge clk);
    reset = 1; tick(); tick();
    reset = 0; tick(); tick(); tick();
    clr(); branch = 1; zero = 1; instruction = 32'h0000_1000; tick();
    instruction = 32'h0000_FF98; tick();
    clr(); branch_ne = 1; zero = 1; tick();
    clr(); branch = 1; branch_ne = 1; zero = 0; instruction = 32'h0000_0004; tick();
    clr(); jump = 1; instruction = 32'h0008_0000; tick();
    clr(); jr = 1; jr_addr = 32'h0000_1002; tick();
    jr_addr = 32'h0000_1000; tick();
    clr(); stall = 1; jr = 1; jr_addr = 32'h3; tick(); tick(); tick();
    clr(); halt = 1; tick(); tick();
    resume = 1; tick();
    clr(); resume = 1; tick();
    clr(); jump = 1; instruction = 32'h40; tick();
    clr(); jal = 1; instruction = 32'h80; tick();
    clr(); ret = 1; jr_addr = 32'h500; tick(); tick();
    clr(); jal = 1; instruction = 32'h40;
    repeat (5) tick();
    ret = 1; tick();
    clr(); jr = 1; jal = 1; jr_addr = 32'h600; tick();
    clr(); jr = 1; jr_addr = 32'hFFFF_FFFC; tick();
    clr(); tick(); tick();
    repeat (800) begin
      reset = $urandom_range(0, 99) == 0;
      halt = $urandom_range(0, 19) == 0;
      resume = $urandom_range(0, 3) == 0;
      stall = $urandom_range(0, 7) == 0;
      ret = $urandom_range(0, 9) == 0;
      jr = $urandom_range(0, 9) == 0;
      jal = $urandom_range(0, 7) == 0;
      jump = $urandom_range(0, 9) == 0;
      branch = $urandom_range(0, 3) == 0;
      branch_ne = $urandom_range(0, 3) == 0;
      zero = $urandom_range(0, 1) == 1;
      instruction = $urandom;
      jr_addr = $urandom & ($urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      tick();
    end
    reset = 0; clr();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
